// File: rtl/cu_pkg.sv
// Shared encodings for the hardwired control unit: opcodes, sequencer states,
// ALU one-hot bit positions and the bundled DataPath control word.
package cu_pkg;

  localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3,  OP_SUB  = 5'd4,  OP_AND  = 5'd5,  OP_OR   = 5'd6;
  localparam logic [4:0] OP_SHR  = 5'd7,  OP_SHRA = 5'd8,  OP_SHL  = 5'd9,  OP_ROR  = 5'd10;
  localparam logic [4:0] OP_ROL  = 5'd11, OP_ADDI = 5'd12, OP_ANDI = 5'd13, OP_ORI  = 5'd14;
  localparam logic [4:0] OP_MUL  = 5'd15, OP_DIV  = 5'd16, OP_NEG  = 5'd17, OP_NOT  = 5'd18;
  localparam logic [4:0] OP_BR   = 5'd19, OP_JR   = 5'd20, OP_JAL  = 5'd21, OP_IN   = 5'd22;
  localparam logic [4:0] OP_OUT  = 5'd23, OP_MFHI = 5'd24, OP_MFLO = 5'd25, OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  typedef enum logic [3:0] {
    RST = 4'd0, T0 = 4'd1, T1 = 4'd2, T2 = 4'd3, T3 = 4'd4,
    T4 = 4'd5, T5 = 4'd6, T6 = 4'd7, T7 = 4'd8, HALT = 4'd9
  } state_e;

  localparam int ALU_W = 13;
  localparam int ALU_AND = 0, ALU_OR = 1, ALU_ADD = 2, ALU_SUB = 3, ALU_MUL = 4;
  localparam int ALU_DIV = 5, ALU_SHR = 6, ALU_SHRA = 7, ALU_SHL = 8, ALU_ROR = 9;
  localparam int ALU_ROL = 10, ALU_NEG = 11, ALU_NOT = 12;

  typedef logic [ALU_W-1:0] alu_op_t;

  typedef struct packed {
    logic pc_out, zlow_out, zhigh_out, mdr_out, hi_out, lo_out, inport_out, c_out, ba_out;
    logic pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in, con_in, outport_in;
    logic gra, grb, grc, r_in, r_out, link;
    logic inc_pc, read, write;
    alu_op_t alu_op;
  } ctrl_t;

  // ALU operation implied by an arithmetic/logic opcode; zero for everything else.
  function automatic alu_op_t alu_for_opcode(input logic [4:0] op);
    alu_op_t sel;
    sel = '0;
    case (op)
      OP_ADD, OP_ADDI: sel[ALU_ADD]  = 1'b1;
      OP_AND, OP_ANDI: sel[ALU_AND]  = 1'b1;
      OP_OR,  OP_ORI:  sel[ALU_OR]   = 1'b1;
      OP_SUB:          sel[ALU_SUB]  = 1'b1;
      OP_SHR:          sel[ALU_SHR]  = 1'b1;
      OP_SHRA:         sel[ALU_SHRA] = 1'b1;
      OP_SHL:          sel[ALU_SHL]  = 1'b1;
      OP_ROR:          sel[ALU_ROR]  = 1'b1;
      OP_ROL:          sel[ALU_ROL]  = 1'b1;
      OP_MUL:          sel[ALU_MUL]  = 1'b1;
      OP_DIV:          sel[ALU_DIV]  = 1'b1;
      OP_NEG:          sel[ALU_NEG]  = 1'b1;
      OP_NOT:          sel[ALU_NOT]  = 1'b1;
      default: ;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/cu_step_decode.sv
// Stateless decode of (state, opcode, BranchOut, Strobe) into the control word.
// CU_INPORT_HANDSHAKE_EN makes `in` wait in T3 until Strobe is high.
module cu_step_decode
  import cu_pkg::*;
(
  input  state_e     state_i,
  input  logic [4:0] opcode_i,
  input  logic       branch_i,
  input  logic       strobe_i,
  output ctrl_t      ctrl_o,
  output logic       last_step_o,
  output logic       stall_o
);

  alu_op_t op_alu;
  assign op_alu = alu_for_opcode(opcode_i);

`ifndef CU_INPORT_HANDSHAKE_EN
  logic unused_strobe;
  assign unused_strobe = strobe_i;
`endif

  always_comb begin
    ctrl_o      = '0;
    last_step_o = 1'b0;
    stall_o     = 1'b0;
    case (state_i)
      T0: begin ctrl_o.pc_out = 1'b1; ctrl_o.mar_in = 1'b1; ctrl_o.inc_pc = 1'b1; ctrl_o.z_in = 1'b1; end
      T1: begin ctrl_o.zlow_out = 1'b1; ctrl_o.pc_in = 1'b1; ctrl_o.read = 1'b1; ctrl_o.mdr_in = 1'b1; end
      T2: begin ctrl_o.mdr_out = 1'b1; ctrl_o.ir_in = 1'b1; end
      T3: case (opcode_i)
        OP_LD, OP_LDI, OP_ST: begin ctrl_o.grb = 1'b1; ctrl_o.ba_out = 1'b1; ctrl_o.y_in = 1'b1; end
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
        OP_ADDI, OP_ANDI, OP_ORI: begin ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.y_in = 1'b1; end
        OP_MUL, OP_DIV: begin ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.y_in = 1'b1; end
        OP_NEG, OP_NOT: begin ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.alu_op = op_alu; ctrl_o.z_in = 1'b1; end
        OP_BR:  begin ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.con_in = 1'b1; end
        OP_JR:  begin ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.pc_in = 1'b1; last_step_o = 1'b1; end
        OP_JAL: begin ctrl_o.pc_out = 1'b1; ctrl_o.link = 1'b1; ctrl_o.r_in = 1'b1; end
        OP_IN: begin
`ifdef CU_INPORT_HANDSHAKE_EN
          if (strobe_i) begin
            ctrl_o.inport_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1; last_step_o = 1'b1;
          end else begin
            stall_o = 1'b1;
          end
`else
          ctrl_o.inport_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1; last_step_o = 1'b1;
`endif
        end
        OP_OUT:  begin ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.outport_in = 1'b1; last_step_o = 1'b1; end
        OP_MFHI: begin ctrl_o.hi_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1; last_step_o = 1'b1; end
        OP_MFLO: begin ctrl_o.lo_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1; last_step_o = 1'b1; end
        default: last_step_o = 1'b1;  // nop, halt and unused opcodes idle for one step
      endcase
      T4: case (opcode_i)
        OP_LD, OP_LDI, OP_ST: begin ctrl_o.c_out = 1'b1; ctrl_o.alu_op[ALU_ADD] = 1'b1; ctrl_o.z_in = 1'b1; end
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL:
          begin ctrl_o.grc = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.alu_op = op_alu; ctrl_o.z_in = 1'b1; end
        OP_ADDI, OP_ANDI, OP_ORI: begin ctrl_o.c_out = 1'b1; ctrl_o.alu_op = op_alu; ctrl_o.z_in = 1'b1; end
        OP_MUL, OP_DIV: begin ctrl_o.grb = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.alu_op = op_alu; ctrl_o.z_in = 1'b1; end
        OP_NEG, OP_NOT: begin ctrl_o.zlow_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1; last_step_o = 1'b1; end
        OP_BR:  begin ctrl_o.pc_out = 1'b1; ctrl_o.y_in = 1'b1; end
        OP_JAL: begin ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.pc_in = 1'b1; last_step_o = 1'b1; end
        default: last_step_o = 1'b1;
      endcase
      T5: case (opcode_i)
        OP_LD, OP_ST: begin ctrl_o.zlow_out = 1'b1; ctrl_o.mar_in = 1'b1; end
        OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHRA, OP_SHL, OP_ROR, OP_ROL,
        OP_ADDI, OP_ANDI, OP_ORI: begin ctrl_o.zlow_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1; last_step_o = 1'b1; end
        OP_MUL, OP_DIV: begin ctrl_o.zlow_out = 1'b1; ctrl_o.lo_in = 1'b1; end
        OP_BR: begin ctrl_o.c_out = 1'b1; ctrl_o.alu_op[ALU_ADD] = 1'b1; ctrl_o.z_in = 1'b1; end
        default: last_step_o = 1'b1;
      endcase
      T6: case (opcode_i)
        OP_LD: begin ctrl_o.read = 1'b1; ctrl_o.mdr_in = 1'b1; end
        OP_ST: begin ctrl_o.gra = 1'b1; ctrl_o.r_out = 1'b1; ctrl_o.write = 1'b1; last_step_o = 1'b1; end
        OP_MUL, OP_DIV: begin ctrl_o.zhigh_out = 1'b1; ctrl_o.hi_in = 1'b1; last_step_o = 1'b1; end
        OP_BR: begin
          ctrl_o.zlow_out = branch_i; ctrl_o.pc_in = branch_i; last_step_o = 1'b1;
        end
        default: last_step_o = 1'b1;
      endcase
      T7: begin
        if (opcode_i == OP_LD) begin ctrl_o.mdr_out = 1'b1; ctrl_o.gra = 1'b1; ctrl_o.r_in = 1'b1; end
        last_step_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore sequencer driving the DataPath: fetch T0-T2, execute T3-T7.
// Optional build macro: CU_INPORT_HANDSHAKE_EN (Strobe-gated `in`).
module control_unit
  import cu_pkg::*;
#(
  parameter int OP_MSB = 31,
  parameter int OP_W   = 5
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        BranchOut,
  input  logic        Strobe,
  output logic        PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout,
  output logic        PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortIn,
  output logic        Gra, Grb, Grc, Rin, Rout, Link,
  output logic        IncPC, Read, Write,
  output logic [12:0] AluOp,
  output logic        Run,
  output logic [3:0]  State
);

  state_e     state_q, state_d;
  ctrl_t      ctrl;
  logic       last_step, stall;
  logic [4:0] opcode;
  logic       unused_ir;

  assign opcode    = 5'(IR[OP_MSB -: OP_W]);
  assign unused_ir = ^IR;

  cu_step_decode u_step_decode (
    .state_i     (state_q),
    .opcode_i    (opcode),
    .branch_i    (BranchOut),
    .strobe_i    (Strobe),
    .ctrl_o      (ctrl),
    .last_step_o (last_step),
    .stall_o     (stall)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      RST:  state_d = T0;
      HALT: state_d = HALT;
      default: begin
        if (stall)
          state_d = state_q;
        else if (last_step)
          state_d = (state_q == T3 && opcode == OP_HALT) ? HALT : T0;
        else
          state_d = state_e'(state_q + 4'd1);
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) state_q <= RST;
    else        state_q <= state_d;
  end

  assign {PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout} =
         {ctrl.pc_out, ctrl.zlow_out, ctrl.zhigh_out, ctrl.mdr_out, ctrl.hi_out,
          ctrl.lo_out, ctrl.inport_out, ctrl.c_out, ctrl.ba_out};
  assign {PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortIn} =
         {ctrl.pc_in, ctrl.mar_in, ctrl.mdr_in, ctrl.ir_in, ctrl.y_in, ctrl.z_in,
          ctrl.hi_in, ctrl.lo_in, ctrl.con_in, ctrl.outport_in};
  assign {Gra, Grb, Grc, Rin, Rout, Link} = {ctrl.gra, ctrl.grb, ctrl.grc, ctrl.r_in, ctrl.r_out, ctrl.link};
  assign {IncPC, Read, Write} = {ctrl.inc_pc, ctrl.read, ctrl.write};
  assign AluOp = ctrl.alu_op;
  assign Run   = (state_q != RST) && (state_q != HALT);
  assign State = state_q;

endmodule

// File: doc/control_unit.md
Name: control_unit

Overview:
- Hardwired Moore sequencer that sits directly upstream of the DataPath and drives every DataPath control input.
- Steps through a fetch sequence (T0-T2), then an opcode-specific execute sequence (T3-T7), then returns to T0.
- Replaces bench-driven control; consumes the IR and CON flip-flop outputs coming back from the DataPath.

Parameters:
- OP_MSB, 31, bit position of the opcode MSB in IR.
- OP_W, 5, opcode width (opcode = IR[OP_MSB -: OP_W]).

Ports:
- Clock  in  1  system clock; state advances on the rising edge.
- Clear  in  1  asynchronous, active-low reset.
- IR  in  32  IR register output from the DataPath; valid from T3 onward.
- BranchOut  in  1  CON flip-flop output.
- Strobe  in  1  input-port data ready.
- PCout, Zlowout, Zhighout, MDRout, HIout, LOout, InPortout, Cout, BAout  out  1 each  bus source selects.
- PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin, CONin, OutPortIn  out  1 each  register loads.
- Gra, Grb, Grc, Rin, Rout, Link  out  1 each  register select/encode; Link forces R15 as the Rin target.
- IncPC, Read, Write  out  1 each  PC increment and memory strobes.
- AluOp  out  13  one-hot ALU operation: bit0 AND, bit1 OR, bit2 ADD, bit3 SUB, bit4 MUL, bit5 DIV, bit6 SHR, bit7 SHRA, bit8 SHL, bit9 ROR, bit10 ROL, bit11 NEG, bit12 NOT.
- Run  out  1  high while executing; low in reset and halt.
- State  out  4  current state encoding, for debug.

Behaviour:
- States: RST=0, T0..T7=1..8, HALT=9.
- Clear low (any time, mid-instruction included): state goes to RST asynchronously and all outputs are 0. First rising edge after Clear releases: RST->T0.
- All outputs are a combinational decode of the state and IR opcode. Any signal not listed for a step is 0.
- Fetch (all instructions):
  - T0: PCout MARin IncPC Zin.
  - T1: Zlowout PCin Read MDRin.
  - T2: MDRout IRin.
- Opcodes:
  - ld=0, ldi=1, st=2.
  - add=3, sub=4, and=5, or=6, shr=7, shra=8, shl=9, ror=10, rol=11.
  - addi=12, andi=13, ori=14.
  - mul=15, div=16, neg=17, not=18.
  - br=19, jr=20, jal=21, in=22, out=23, mfhi=24, mflo=25, nop=26, halt=27.
  - Opcodes 28-31 execute as nop.
- Execute steps; the last listed step returns to T0:
  - ld: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  - ldi: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout Gra Rin.
  - st: T3-T5 as ld; T6 Gra Rout Write.
  - R-type (3-11): T3 Grb Rout Yin; T4 Grc Rout op Zin; T5 Zlowout Gra Rin.
  - addi/andi/ori: T3 Grb Rout Yin; T4 Cout op Zin (ADD/AND/OR); T5 Zlowout Gra Rin.
  - mul/div: T3 Gra Rout Yin; T4 Grb Rout op Zin; T5 Zlowout LOin; T6 Zhighout HIin.
  - neg/not: T3 Grb Rout op Zin; T4 Zlowout Gra Rin.
  - br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ADD Zin; T6 Zlowout PCin only if BranchOut=1, otherwise T6 is idle.
  - jr: T3 Gra Rout PCin.
  - jal: T3 PCout Link Rin; T4 Gra Rout PCin.
  - in: T3 InPortout Gra Rin.
  - out: T3 Gra Rout OutPortIn.
  - mfhi: T3 HIout Gra Rin. mflo: T3 LOout Gra Rin.
  - nop: T3 idle.
  - halt: T3 idle, then HALT.
- HALT: all outputs 0, Run=0. Only Clear exits HALT.
- Opcode is read from IR only in T3-T7. IR changes at the T2 edge and is stable afterwards.
- BranchOut is sampled combinationally in T6.

Optional Feature:
- Macro: CU_INPORT_HANDSHAKE_EN.
- Defined: for `in`, the FSM holds in T3 with all outputs 0 while Strobe=0. When Strobe=1, T3 asserts InPortout Gra Rin for that cycle and goes to T0.
- Not defined: Strobe is ignored; `in` completes in one T3 cycle.

Decomposition:
- Package cu_pkg holds:
  - the opcode localparams (ld..halt);
  - the state encodings RST, T0..T7, HALT;
  - the AluOp bit indices and a typedef for the 13-bit one-hot vector.
- One sub-module: cu_step_decode. It is purely combinational, maps (state, opcode, BranchOut, Strobe) to control outputs plus a last_step flag, and contains no state.
- The top module holds the state register and the next-state logic.

Test Plan:
- Release Clear; IR=ldi (opcode 1) -> State goes RST,T0,T1,T2,T3,T4,T5,T0. T4: AluOp=13'h0004, Cout=1. T5: Zlowout=Gra=Rin=1.
- IR=ld -> 8 cycles T0-T7; Read=1 in T1 and T6; MDRout=1 in T2 and T7; Write never asserted.
- IR=br with BranchOut=1 -> PCin=1 in T6. Repeat with BranchOut=0 -> PCin=0 in T6, next state T0.
- IR=mul -> T4 AluOp=13'h0010; T5 LOin=1; T6 HIin=Zhighout=1; next state T0.
- IR=halt -> HALT after T3, Run=0, outputs stay 0 for 20 cycles. Pull Clear low for 1 ns mid-cycle -> State=0 immediately; restarts at T0 after release.
- Macro defined, IR=in, Strobe low for 5 cycles -> stays in T3 with Rin=0; Strobe=1 -> Rin=InPortout=1 for one cycle, then T0.
